// File: rtl/led_cmd_tx.sv
// Panel command transmitter: encodes one high-level LED command into 1 or 2
// protocol bytes and shifts them out as 8N1 UART, LSB first.
module led_cmd_tx #(
    parameter int CLKS_PER_BIT = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_col,
    input  logic [2:0] cmd_row,
    input  logic [2:0] cmd_rgb,
    output logic       uart_tx,
    output logic       tx_done,
    output logic       cmd_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]       bit_idx, bit_idx_next, bit_inc;
    logic             byte_sel, byte_sel_next;
    logic [7:0]       byte0, byte0_next, byte1, byte1_next;
    logic             two_byte, two_byte_next;
    logic             uart_tx_next, tx_done_next, cmd_err_next;
    logic [7:0]       pixel_byte, cur_byte;
    logic             bit_end;

    assign cmd_ready = (state == IDLE) && !reset;

    always_comb begin
        pixel_byte    = {cmd_col, 1'b0, cmd_row};
        cur_byte      = byte_sel ? byte1 : byte0;
        bit_end       = (clk_cnt == CNT_MAX);
        bit_inc       = bit_idx + 3'd1;

        state_next    = state;
        clk_cnt_next  = bit_end ? '0 : clk_cnt + 1'b1;
        bit_idx_next  = bit_idx;
        byte_sel_next = byte_sel;
        byte0_next    = byte0;
        byte1_next    = byte1;
        two_byte_next = two_byte;
        uart_tx_next  = uart_tx;
        tx_done_next  = 1'b0;
        cmd_err_next  = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_next  = '0;
                bit_idx_next  = '0;
                byte_sel_next = 1'b0;
                uart_tx_next  = 1'b1;
                if (cmd_valid) begin
                    // The line drops straight into the start bit on acceptance.
                    state_next    = START;
                    uart_tx_next  = 1'b0;
                    two_byte_next = 1'b0;
                    byte1_next    = pixel_byte;
                    case (cmd_op)
                        3'd0: byte0_next = {5'b00000, cmd_rgb};
                        3'd1: begin
                            byte0_next    = 8'h10;
                            two_byte_next = 1'b1;
                        end
                        3'd2: begin
                            byte0_next    = 8'h20;
                            two_byte_next = 1'b1;
                        end
                        3'd3: byte0_next = 8'h30;
                        3'd4: byte0_next = 8'hF0;
                        default: begin
                            state_next   = IDLE;
                            uart_tx_next = 1'b1;
                            cmd_err_next = 1'b1;
                        end
                    endcase
                end
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    uart_tx_next = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_next   = STOP;
                        uart_tx_next = 1'b1;
                    end else begin
                        bit_idx_next = bit_inc;
                        uart_tx_next = cur_byte[bit_inc];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_byte && !byte_sel) begin
                        state_next    = START;
                        byte_sel_next = 1'b1;
                        uart_tx_next  = 1'b0;
                    end else begin
                        state_next   = IDLE;
                        tx_done_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_sel <= 1'b0;
            byte0    <= '0;
            byte1    <= '0;
            two_byte <= 1'b0;
            uart_tx  <= 1'b1;
            tx_done  <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_idx  <= bit_idx_next;
            byte_sel <= byte_sel_next;
            byte0    <= byte0_next;
            byte1    <= byte1_next;
            two_byte <= two_byte_next;
            uart_tx  <= uart_tx_next;
            tx_done  <= tx_done_next;
            cmd_err  <= cmd_err_next;
        end
    end

endmodule

// File: doc/led_cmd_tx.md
# led_cmd_tx

Host-side UART command transmitter for the LED panel driver. It accepts one high-level panel command per valid/ready handshake, encodes it into the panel's 1- or 2-byte command protocol, and serializes the bytes as 8N1 UART. Its `uart_tx` connects directly to the panel driver's UART receive input. It drives the panel from on-chip logic (pattern generators, test sequencers) and gives benches a bit-exact stimulus source.

## Interface
- `CLKS_PER_BIT`, default 20: clk cycles per UART bit. Must be ≥ 2 and must match the panel receiver.
- `clk` input 1: clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `cmd_valid` input 1: command present on `cmd_*`.
- `cmd_ready` output 1: block idle, able to accept a command.
- `cmd_op` input 3: 0 SET_RGB, 1 SET_PIXEL, 2 CLR_PIXEL, 3 CLEAR_SCREEN, 4 SYNC, 5-7 reserved.
- `cmd_col` input 4: pixel column 0-15; used by ops 1 and 2.
- `cmd_row` input 3: pixel row 0-7; used by ops 1 and 2.
- `cmd_rgb` input 3: colour {r,g,b}; used by op 0.
- `uart_tx` output 1: serial line, idle high.
- `tx_done` output 1: one-cycle pulse when the last stop bit of a command completes.
- `cmd_err` output 1: one-cycle pulse when a reserved op is accepted.

## Operation
- Handshake: a command is accepted on a rising edge where `cmd_valid && cmd_ready`.
  - On acceptance, `cmd_op`, `cmd_col`, `cmd_row` and `cmd_rgb` are latched.
  - Inputs are ignored at all other times. `cmd_valid` while busy has no effect.
- `cmd_ready` = (state == IDLE) && !reset, combinational from registered state.
- Encoding (pixel byte = {col[3:0], 1'b0, row[2:0]}):
  - SET_RGB → 0x00 | rgb.
  - SET_PIXEL → 0x10, then pixel byte.
  - CLR_PIXEL → 0x20, then pixel byte.
  - CLEAR_SCREEN → 0x30.
  - SYNC → 0xF0.
  - Reserved ops → no bytes. `cmd_err` pulses in the cycle after acceptance, and the block stays IDLE.
- A pixel byte can never equal 0xFF because bit 3 is always 0. The abort code is therefore never emitted.
- Framing:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit holds `uart_tx` for exactly `CLKS_PER_BIT` cycles.
- State machine: IDLE → START → DATA (bit_idx 0..7) → STOP.
  - From STOP: if a second byte is pending, go to START (no gap). Otherwise go to IDLE and pulse `tx_done`.
- Counters:
  - `clk_cnt` is `$clog2(CLKS_PER_BIT)` bits wide, counts 0..CLKS_PER_BIT-1, and wraps to 0 on each bit boundary.
  - `bit_idx` is 3 bits wide.
  - `byte_sel` is 1 bit wide and marks first or second byte.
- `uart_tx` is a registered output. It is high in IDLE and during STOP.
- Reset, including mid-frame:
  - Next clock: `uart_tx`=1, state IDLE, counters 0, `tx_done`=0, `cmd_err`=0.
  - `cmd_ready` reads 0 while reset is high.
  - A partially sent byte is abandoned. Upstream recovers the panel by sending SYNC.

## Timing
- Acceptance at edge N. `uart_tx` falls (start bit) in the cycle after edge N.
- With C = `CLKS_PER_BIT`:
  - 1-byte command: line busy 10·C cycles. `tx_done` high and `cmd_ready` high in cycle N+1+10·C.
  - 2-byte command: the second start bit immediately follows the first stop bit. Line busy 20·C cycles. `tx_done`/`cmd_ready` in cycle N+1+20·C.
- Back-to-back commands with `cmd_valid` held: the next acceptance happens in the `tx_done` cycle. The next start bit follows one cycle later, so there is exactly one idle-high cycle between commands.
- Reserved op: `cmd_err` is high only in cycle N+1, and `cmd_ready` is high in cycle N+1.
- Reset values of all outputs: `uart_tx`=1, `cmd_ready`=0 while reset is asserted, `tx_done`=0, `cmd_err`=0.

## Test plan
- SET_RGB rgb=3'b101, C=20, accept at N → bench UART decoder reads 0x05. Start bit edge in cycle N+1. `tx_done`/`cmd_ready` in cycle N+201.
- SET_PIXEL col=9 row=5 → bytes 0x10, 0x95, contiguous with no idle cycle between them. `tx_done` in cycle N+401. Each bit is exactly 20 cycles.
- CLR_PIXEL col=15 row=7, then CLEAR_SCREEN with `cmd_valid` held:
  - Bytes 0x20, 0xF7, 0x30 are sent.
  - Exactly one idle-high cycle separates 0xF7's stop bit from 0x30's start bit.
  - `cmd_valid` toggling while busy changes nothing.
- Op 6 → `cmd_err` is a single-cycle pulse, `uart_tx` stays high, `tx_done` never pulses, and `cmd_ready` is high in cycle N+1.
- Reset asserted at data bit 3 of 0x10 →
  - `uart_tx`=1 next cycle and `cmd_ready`=0 during reset.
  - After release, SYNC emits a clean 0xF0 starting one cycle after acceptance.
- End-to-end with the panel driver's UART decoder (same C): send 0x30, then SET_PIXEL col=4 row=2 → panel frame buffer column 4 = 8'b00000100 and decoder back in CTRL state.
